atm_keypad_entry: RTL

Keypad front end for the `ATM` core. Converts a stream of single-key events (digits 0–9, ENTER, CLEAR, CANCEL, LANG) into the registered `accNumber`, `pin`, `destinationAccNumber`, `menuOption`, `amount` and `lang` inputs that `ATM` consumes. Each operation is issued to `ATM` as a one-cycle `menuOption` strobe. An inactivity timer ends abandoned sessions.

---
 rtl/atm_pkg.sv | 45 ++++
 rtl/atm_keypad_entry_if.sv | 28 ++
 rtl/atm_digit_accum.sv | 39 +++
 rtl/atm_keypad_entry.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM keypad front end: menu opcodes, key codes,
// entry FSM states, per-field digit maxima and language values.
package atm_pkg;

    typedef enum logic [2:0] {
        WAITING               = 3'd0,
        MENU                  = 3'd2,
        BALANCE               = 3'd3,
        WITHDRAW              = 3'd4,
        WITHDRAW_SHOW_BALANCE = 3'd5,
        TRANSACTION           = 3'd6,
        DEPOSIT               = 3'd7
    } menu_op_e;

    typedef enum logic [3:0] {
        KEY_ENTER  = 4'hA,
        KEY_CLEAR  = 4'hB,
        KEY_CANCEL = 4'hC,
        KEY_LANG   = 4'hD
    } key_code_e;

    typedef enum logic [2:0] {
        ST_ACC    = 3'd0,
        ST_PIN    = 3'd1,
        ST_MENU   = 3'd2,
        ST_DEST   = 3'd3,
        ST_AMOUNT = 3'd4,
        ST_ISSUE  = 3'd5
    } entry_st_e;

    localparam logic [11:0] MAX_ACC    = 12'd4095;
    localparam logic [11:0] MAX_PIN    = 12'd15;
    localparam logic [11:0] MAX_MENU   = 12'd7;
    localparam logic [11:0] MAX_DEST   = 12'd4095;
    localparam logic [11:0] MAX_AMOUNT = 12'd2047;

    localparam logic LANG_EN = 1'b0;
    localparam logic LANG_AR = 1'b1;

    // Decimal shift-in, kept 16 bits wide so overflow past a field maximum is visible.
    function automatic logic [15:0] shift_in_digit(input logic [11:0] acc, input logic [3:0] d);
        return ({4'h0, acc} * 16'd10) + {12'h000, d};
    endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Key-event input and registered ATM-facing outputs of the keypad front end.
interface atm_keypad_entry_if;

    logic        key_valid;
    logic [3:0]  key_code;
    logic        lang;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic [11:0] destinationAccNumber;
    logic [2:0]  menuOption;
    logic [10:0] amount;
    logic [2:0]  entry_state;
    logic        key_err;
    logic        timeout;

    modport master (
        output key_valid, key_code,
        input  lang, accNumber, pin, destinationAccNumber, menuOption,
               amount, entry_state, key_err, timeout
    );

    modport slave (
        input  key_valid, key_code,
        output lang, accNumber, pin, destinationAccNumber, menuOption,
               amount, entry_state, key_err, timeout
    );

endinterface

// File: rtl/atm_digit_accum.sv
// Decimal digit accumulator shared by every entry field; the field limit is
// supplied at runtime so one instance serves all states.
module atm_digit_accum
    import atm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic [11:0] max,
    output logic [11:0] value,
    output logic [2:0]  count,
    output logic        reject
);

    logic [15:0] shifted;

    always_comb begin
        shifted = shift_in_digit(value, digit);
        reject  = digit_valid && !clear && (shifted > {4'h0, max});
    end

    // Count saturates so long runs of leading zeros never wrap back to "empty".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (digit_valid && !reject) begin
            value <= shifted[11:0];
            if (count != '1)
                count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry FSM: turns key events into committed ATM fields and a
// one-cycle menuOption strobe, with an inactivity timeout.
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100
)
(
    input logic               clk,
    input logic               rst,
    atm_keypad_entry_if.slave bus
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    entry_st_e   state;
    logic [TW-1:0] timer;
    logic        lang_q;
    logic [11:0] acc_number_q;
    logic [3:0]  pin_q;
    logic [11:0] dest_q;
    logic [10:0] amount_q;
    logic [2:0]  menu_opt_q;
    logic [2:0]  op_q;
    logic        key_err_q;
    logic        timeout_q;

    logic [11:0] acc_value;
    logic [2:0]  acc_count;
    logic        acc_reject;
    logic [11:0] field_max;
    logic        key_act, is_digit, is_enter, is_clear, is_cancel, is_lang, is_illegal;
    logic        timer_run, expire, acc_clear, acc_digit;

    always_comb begin
        key_act    = bus.key_valid && (state != ST_ISSUE);
        is_digit   = bus.key_code <= 4'd9;
        is_enter   = bus.key_code == KEY_ENTER;
        is_clear   = bus.key_code == KEY_CLEAR;
        is_cancel  = bus.key_code == KEY_CANCEL;
        is_lang    = bus.key_code == KEY_LANG;
        is_illegal = bus.key_code >= 4'hE;

        field_max = '0;
        case (state)
            ST_ACC:    field_max = MAX_ACC;
            ST_PIN:    field_max = MAX_PIN;
            ST_MENU:   field_max = MAX_MENU;
            ST_DEST:   field_max = MAX_DEST;
            ST_AMOUNT: field_max = MAX_AMOUNT;
            default:   field_max = '0;
        endcase

        timer_run = (state != ST_ACC) || (acc_count != '0);
        expire    = !bus.key_valid && (state != ST_ISSUE) && timer_run &&
                    (timer == TW'(TIMEOUT_CYCLES - 1));
        acc_digit = key_act && is_digit;
        // Any ENTER with digits empties the accumulator, whether accepted or a rejected menu code.
        acc_clear = expire ||
                    (key_act && (is_clear || is_cancel || (is_enter && acc_count != '0)));
    end

    atm_digit_accum u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear       (acc_clear),
        .digit_valid (acc_digit),
        .digit       (bus.key_code),
        .max         (field_max),
        .value       (acc_value),
        .count       (acc_count),
        .reject      (acc_reject)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ACC;
            timer        <= '0;
            lang_q       <= LANG_EN;
            acc_number_q <= '0;
            pin_q        <= '0;
            dest_q       <= '0;
            amount_q     <= '0;
            menu_opt_q   <= WAITING;
            op_q         <= WAITING;
            key_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            key_err_q <= 1'b0;
            timeout_q <= 1'b0;

            if (bus.key_valid)
                timer <= '0;
            else if (state == ST_ISSUE)
                timer <= timer;
            else if (expire || !timer_run)
                timer <= '0;
            else
                timer <= timer + TW'(1);

            if (state == ST_ISSUE) begin
                state      <= ST_MENU;
                menu_opt_q <= WAITING;
            end else if (expire || (bus.key_valid && is_cancel)) begin
                state        <= ST_ACC;
                acc_number_q <= '0;
                pin_q        <= '0;
                dest_q       <= '0;
                amount_q     <= '0;
                menu_opt_q   <= WAITING;
                op_q         <= WAITING;
                timeout_q    <= expire;
            end else if (bus.key_valid) begin
                if (is_digit) begin
                    key_err_q <= acc_reject;
                end else if (is_enter) begin
                    if (acc_count == '0) begin
                        key_err_q <= 1'b1;
                    end else begin
                        case (state)
                            ST_ACC: begin
                                acc_number_q <= acc_value;
                                state        <= ST_PIN;
                            end
                            ST_PIN: begin
                                pin_q <= acc_value[3:0];
                                state <= ST_MENU;
                            end
                            ST_MENU: begin
                                op_q <= acc_value[2:0];
                                case (acc_value[2:0])
                                    BALANCE: begin
                                        state      <= ST_ISSUE;
                                        menu_opt_q <= BALANCE;
                                    end
                                    WITHDRAW, WITHDRAW_SHOW_BALANCE, DEPOSIT:
                                        state <= ST_AMOUNT;
                                    TRANSACTION:
                                        state <= ST_DEST;
                                    default:
                                        key_err_q <= 1'b1;
                                endcase
                            end
                            ST_DEST: begin
                                dest_q <= acc_value;
                                state  <= ST_AMOUNT;
                            end
                            ST_AMOUNT: begin
                                amount_q   <= acc_value[10:0];
                                state      <= ST_ISSUE;
                                menu_opt_q <= op_q;
                            end
                            default: state <= ST_ACC;
                        endcase
                    end
                end else if (is_lang) begin
                    lang_q <= ~lang_q;
                end else if (is_illegal) begin
                    key_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.entry_state          = state;
    assign bus.lang                 = lang_q;
    assign bus.accNumber            = acc_number_q;
    assign bus.pin                  = pin_q;
    assign bus.destinationAccNumber = dest_q;
    assign bus.amount               = amount_q;
    assign bus.menuOption           = menu_opt_q;
    assign bus.key_err              = key_err_q;
    assign bus.timeout              = timeout_q;

endmodule
